// File: rtl/tpu_gemm_seq.sv
// GEMM sequencer: tiles an m x k x n problem into ARR x ARR output tiles, streams
// operand reads from GBUFF_A/GBUFF_B into the TPU and routes result beats to GBUFF_OUT.
module tpu_gemm_seq #(
    parameter int ADDR_W = 10,
    parameter int DIM_W  = 8,
    parameter int ARR    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIM_W-1:0]  m,
    input  logic [DIM_W-1:0]  k,
    input  logic [DIM_W-1:0]  n,
    input  logic [ADDR_W-1:0] a_base,
    input  logic [ADDR_W-1:0] b_base,
    input  logic [ADDR_W-1:0] out_base,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic              rd_en,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    output logic              tpu_in_valid,
    output logic              tpu_in_last,
    input  logic              tpu_out_valid,
    input  logic              tpu_done,
    output logic              out_wen,
    output logic [ADDR_W-1:0] out_addr
);
    localparam int LG = $clog2(ARR);

    typedef enum logic [2:0] {IDLE, CHECK, STREAM, DRAIN, FIN} state_t;
    state_t state;

    logic [DIM_W-1:0]  m_q, k_q, n_q;
    logic [ADDR_W-1:0] a_base_q, b_base_q, out_base_q;
    logic [DIM_W-1:0]  rt, ct, kk;
    logic [ADDR_W-1:0] a_off, b_off, obeat;
    logic [ADDR_W-1:0] k_a, kk_a;
    logic              kk_last, rt_last, ct_last;

    assign k_a     = ADDR_W'(k_q);
    assign kk_a    = ADDR_W'(kk);
    assign kk_last = (kk == k_q - DIM_W'(1));
    // Last tile index is (dim-1)/ARR; only evaluated once CHECK has ruled out zero dims.
    assign rt_last = (rt == ((m_q - DIM_W'(1)) >> LG));
    assign ct_last = (ct == ((n_q - DIM_W'(1)) >> LG));

    assign rd_en    = (state == STREAM);
    assign a_addr   = a_base_q + a_off + kk_a;
    assign b_addr   = b_base_q + b_off + kk_a;
    assign out_wen  = busy & tpu_out_valid;
    assign out_addr = out_base_q + obeat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            cfg_err      <= 1'b0;
            tpu_in_valid <= 1'b0;
            tpu_in_last  <= 1'b0;
            m_q          <= '0;
            k_q          <= '0;
            n_q          <= '0;
            a_base_q     <= '0;
            b_base_q     <= '0;
            out_base_q   <= '0;
            rt           <= '0;
            ct           <= '0;
            kk           <= '0;
            a_off        <= '0;
            b_off        <= '0;
            obeat        <= '0;
        end else begin
            // Operand valid trails the read address by the SRAM's one-cycle latency.
            tpu_in_valid <= rd_en;
            tpu_in_last  <= rd_en & kk_last;
            done         <= 1'b0;
            if (out_wen) obeat <= obeat + ADDR_W'(1);

            case (state)
                IDLE: if (start) begin
                    m_q        <= m;
                    k_q        <= k;
                    n_q        <= n;
                    a_base_q   <= a_base;
                    b_base_q   <= b_base;
                    out_base_q <= out_base;
                    cfg_err    <= 1'b0;
                    busy       <= 1'b1;
                    state      <= CHECK;
                end
                CHECK: begin
                    if (m_q == '0 || k_q == '0 || n_q == '0) begin
                        cfg_err <= 1'b1;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= FIN;
                    end else begin
                        rt    <= '0;
                        ct    <= '0;
                        kk    <= '0;
                        a_off <= '0;
                        b_off <= '0;
                        obeat <= '0;
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    if (kk_last) begin
                        kk    <= '0;
                        state <= DRAIN;
                    end else begin
                        kk <= kk + DIM_W'(1);
                    end
                end
                DRAIN: if (tpu_done) begin
                    // Row/column offsets advance by k per tile so no multiplier is needed.
                    if (ct_last) begin
                        ct    <= '0;
                        b_off <= '0;
                        rt    <= rt + DIM_W'(1);
                        a_off <= a_off + k_a;
                    end else begin
                        ct    <= ct + DIM_W'(1);
                        b_off <= b_off + k_a;
                    end
                    if (rt_last && ct_last) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= FIN;
                    end else begin
                        state <= STREAM;
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tpu_gemm_seq.sv
// Bench for tpu_gemm_seq: table of GEMM jobs with a read/write address scoreboard
// and a small TPU responder, plus hand-written reset and start-while-busy sequences.
module tb_tpu_gemm_seq;
    localparam int ARR = 8;

    logic       clk = 1'b0;
    logic       rst, start;
    logic [7:0] m, k, n;
    logic [9:0] a_base, b_base, out_base;
    logic       busy, done, cfg_err, rd_en;
    logic [9:0] a_addr, b_addr, out_addr;
    logic       tpu_in_valid, tpu_in_last, tpu_out_valid, tpu_done, out_wen;

    always #5 clk = ~clk;

    tpu_gemm_seq #(.ADDR_W(10), .DIM_W(8), .ARR(ARR)) dut (
        .clk(clk), .rst(rst), .start(start), .m(m), .k(k), .n(n),
        .a_base(a_base), .b_base(b_base), .out_base(out_base),
        .busy(busy), .done(done), .cfg_err(cfg_err), .rd_en(rd_en),
        .a_addr(a_addr), .b_addr(b_addr), .tpu_in_valid(tpu_in_valid),
        .tpu_in_last(tpu_in_last), .tpu_out_valid(tpu_out_valid),
        .tpu_done(tpu_done), .out_wen(out_wen), .out_addr(out_addr)
    );

    typedef struct {
        logic [9:0] a;
        logic [9:0] b;
        logic       last;
    } rd_t;

    typedef struct {
        int         m, k, n;
        logic [9:0] ab, bb, ob;
        bit         err;
        bit         ovl;
        bit         extra;
    } case_t;

    rd_t        rq[$];
    logic [9:0] oq[$];
    case_t      tbl[8];

    int   checks = 0, errors = 0, cyc = 0;
    bit   chk_en = 1, exp_iv = 0, exp_il = 0, ovl = 0;
    int   beats_left = 0;
    bit   pend_done = 0;
    int   done_cnt = 0, done_cyc = -1, last_td = -1;
    logic cfg_at_done = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic sample();
        rd_t        e;
        logic [9:0] o;
        if (!chk_en) begin
            exp_iv = 0;
            exp_il = 0;
        end else begin
            chk("tpu_in_valid", 32'(tpu_in_valid), 32'(exp_iv));
            chk("tpu_in_last", 32'(tpu_in_last), 32'(exp_il));
            exp_iv = 0;
            exp_il = 0;
            if (rd_en) begin
                if (rq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rd_unexpected: got read a=0x%0h b=0x%0h expected none (cycle %0d)",
                             a_addr, b_addr, cyc);
                end else begin
                    e = rq.pop_front();
                    chk("a_addr", 32'(a_addr), 32'(e.a));
                    chk("b_addr", 32'(b_addr), 32'(e.b));
                    exp_iv = 1;
                    exp_il = e.last;
                end
            end
            if (out_wen) begin
                if (oq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wr_unexpected: got write 0x%0h expected none (cycle %0d)", out_addr, cyc);
                end else begin
                    o = oq.pop_front();
                    chk("out_addr", 32'(out_addr), 32'(o));
                end
            end
        end
        if (tpu_done) begin
            last_td = cyc;
            if (rd_en) begin
                checks++; errors++;
                $display("FAIL tpu_done_in_stream: got tpu_done during reads expected none (cycle %0d)", cyc);
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc    = cyc;
            cfg_at_done = cfg_err;
            chk("busy_at_done", 32'(busy), 32'(0));
        end
    endtask

    // TPU stand-in: ARR result beats after the last operand, then tpu_done
    // either on the final beat (ovl) or the cycle after it.
    task automatic tpu_model();
        tpu_out_valid = 0;
        tpu_done      = 0;
        if (beats_left > 0) begin
            tpu_out_valid = 1;
            beats_left--;
            if (beats_left == 0) begin
                if (ovl) tpu_done = 1;
                else     pend_done = 1;
            end
        end else if (pend_done) begin
            tpu_done  = 1;
            pend_done = 0;
        end
        if (tpu_in_last) beats_left = ARR;
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        cyc++;
        #1;
        tpu_model();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_cfg_err"}, 32'(cfg_err), 0);
        chk({tag, "_rd_en"}, 32'(rd_en), 0);
        chk({tag, "_a_addr"}, 32'(a_addr), 0);
        chk({tag, "_b_addr"}, 32'(b_addr), 0);
        chk({tag, "_in_valid"}, 32'(tpu_in_valid), 0);
        chk({tag, "_in_last"}, 32'(tpu_in_last), 0);
        chk({tag, "_out_wen"}, 32'(out_wen), 0);
        chk({tag, "_out_addr"}, 32'(out_addr), 0);
    endtask

    task automatic run_case(input case_t c);
        int rtn, ctn, st, d0;
        rtn = (c.m + ARR - 1) / ARR;
        ctn = (c.n + ARR - 1) / ARR;
        if (!c.err) begin
            for (int r = 0; r < rtn; r++)
                for (int q = 0; q < ctn; q++)
                    for (int i = 0; i < c.k; i++)
                        rq.push_back('{a: 10'(int'(c.ab) + r * c.k + i),
                                       b: 10'(int'(c.bb) + q * c.k + i),
                                       last: (i == c.k - 1)});
            for (int j = 0; j < rtn * ctn * ARR; j++)
                oq.push_back(10'(int'(c.ob) + j));
        end
        ovl      = c.ovl;
        m        = 8'(c.m);
        k        = 8'(c.k);
        n        = 8'(c.n);
        a_base   = c.ab;
        b_base   = c.bb;
        out_base = c.ob;
        start    = 1;
        st       = cyc;
        d0       = done_cnt;
        step();
        start = 0;
        chk("busy_after_start", 32'(busy), 1);
        chk("cfg_err_cleared", 32'(cfg_err), 0);
        for (int i = 0; i < 3000 && done_cnt == d0; i++) begin
            if (c.extra && i == 2) begin
                start  = 1;
                a_base = 10'h200;
            end else begin
                start = 0;
            end
            step();
        end
        start = 0;
        chk("done_seen", 32'(done_cnt - d0), 1);
        if (c.err) chk("done_latency_start", 32'(done_cyc - st), 2);
        else       chk("done_latency_tpu", 32'(done_cyc - last_td), 1);
        chk("cfg_err_at_done", 32'(cfg_at_done), 32'(c.err));
        repeat (3) step();
        chk("single_done", 32'(done_cnt - d0), 1);
        chk("reads_left", 32'(rq.size()), 0);
        chk("writes_left", 32'(oq.size()), 0);
        chk("idle_busy", 32'(busy), 0);
        rq.delete();
        oq.delete();
    endtask

    initial begin
        int d0;
        tbl[0] = '{8,  4, 8,  10'h010, 10'h040, 10'h100, 0, 1, 0};
        tbl[1] = '{16, 3, 8,  10'h010, 10'h040, 10'h100, 0, 0, 0};
        tbl[2] = '{8,  2, 16, 10'h010, 10'h040, 10'h100, 0, 1, 0};
        tbl[3] = '{8,  0, 8,  10'h010, 10'h040, 10'h100, 1, 0, 0};
        tbl[4] = '{8,  4, 8,  10'h3FE, 10'h040, 10'h100, 0, 0, 0};
        tbl[5] = '{9,  2, 3,  10'h020, 10'h030, 10'h3FC, 0, 1, 0};
        tbl[6] = '{0,  3, 5,  10'h020, 10'h030, 10'h000, 1, 0, 0};
        tbl[7] = '{8,  4, 8,  10'h010, 10'h040, 10'h100, 0, 0, 1};

        rst = 1; start = 0; m = 0; k = 0; n = 0;
        a_base = 0; b_base = 0; out_base = 0;
        tpu_out_valid = 0; tpu_done = 0;
        repeat (3) step();
        chk_zero("reset");
        rst = 0;
        step();

        foreach (tbl[i]) run_case(tbl[i]);

        // Reset in the middle of streaming the 16x3x8 job.
        chk_en   = 0;
        m        = 8'd16; k = 8'd3; n = 8'd8;
        a_base   = 10'h010; b_base = 10'h040; out_base = 10'h100;
        start    = 1;
        step();
        start = 0;
        step();
        step();
        chk("rd_en_before_rst", 32'(rd_en), 1);
        rst = 1;
        step();
        chk_zero("mid_rst");
        rst = 0;
        d0  = done_cnt;
        repeat (6) step();
        chk("no_done_after_rst", 32'(done_cnt - d0), 0);
        chk("rd_en_after_rst", 32'(rd_en), 0);
        chk_en = 1;
        step();

        run_case(tbl[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
